// File: rtl/sparse_syn_accum_pkg.sv
// Shared constants and FSM state type for the sparse synaptic accumulator.
package snn_pkg;
  localparam int N_IN  = 8;
  localparam int N_OUT = 4;
  localparam int W_W   = 4;
  localparam int CUR_W = 8;
  localparam int IDX_W = $clog2(N_IN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sparse_syn_accum_if.sv
// Spike-vector handshake, weight-write port and current outputs of sparse_syn_accum.
interface sparse_syn_accum_if
  import snn_pkg::*;
#(
  parameter int N_IN_P  = N_IN,
  parameter int N_OUT_P = N_OUT,
  parameter int W_W_P   = W_W,
  parameter int CUR_W_P = CUR_W,
  parameter int IDX_W_P = (N_IN_P > 1) ? $clog2(N_IN_P) : 1
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_IN_P-1:0]          spike_in;
  logic                       w_we;
  logic [IDX_W_P-1:0]         w_addr;
  logic [N_OUT_P*W_W_P-1:0]   w_data;
  logic [N_OUT_P*CUR_W_P-1:0] cur_out;
  logic                       out_valid;
  logic                       busy;

  modport master (
    output in_valid, spike_in, w_we, w_addr, w_data,
    input  in_ready, cur_out, out_valid, busy
  );

  modport slave (
    input  in_valid, spike_in, w_we, w_addr, w_data,
    output in_ready, cur_out, out_valid, busy
  );
endinterface

// File: rtl/sparse_syn_accum_lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit, plus any/last-bit flags.
module lowest_set_idx #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          last
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign any  = |mask;
  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  assign last = any && ((mask & (mask - W'(1))) == '0);
endmodule

// File: rtl/sparse_syn_accum.sv
// Sparsity-aware synaptic accumulator: visits set spike bits one per cycle and sums weight rows.
// Build option SYN_SAT_EN: saturate per-neuron currents at full scale instead of wrapping.
module sparse_syn_accum
  import snn_pkg::*;
#(
  parameter int N_IN_P  = N_IN,
  parameter int N_OUT_P = N_OUT,
  parameter int W_W_P   = W_W,
  parameter int CUR_W_P = CUR_W,
  parameter int IDX_W_P = (N_IN_P > 1) ? $clog2(N_IN_P) : 1
) (
  input logic clk,
  input logic rst_n,
  sparse_syn_accum_if.slave bus
);
  state_t state_reg, state_next;
  logic [N_IN_P-1:0]        mask_reg, mask_next;
  logic [N_OUT_P*W_W_P-1:0] weight_reg [N_IN_P];
  logic [N_OUT_P*W_W_P-1:0] row_sel;
  logic [IDX_W_P-1:0]       scan_idx;
  logic                     mask_any, mask_last;
  logic                     accept, load_out;
  logic                     in_ready_c, busy_c, out_valid_c;

  lowest_set_idx #(.W(N_IN_P), .IW(IDX_W_P)) u_lsi (
    .mask (mask_reg),
    .idx  (scan_idx),
    .any  (mask_any),
    .last (mask_last)
  );

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          mask_next  = bus.spike_in;
          state_next = (|bus.spike_in) ? SCAN : DONE;
        end
      end
      SCAN: begin
        busy_c    = 1'b1;
        mask_next = mask_reg & (mask_reg - N_IN_P'(1));
        if (!mask_any || mask_last) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept   = (state_reg == IDLE) && bus.in_valid;
  // cur_out is loaded on the edge entering DONE so it is valid alongside out_valid.
  assign load_out = (state_next == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
    end
  end

  // Combinational read sees the pre-write row when a write hits the row being scanned.
  assign row_sel = weight_reg[scan_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN_P; i++) weight_reg[i] <= '0;
    end else if (bus.w_we) begin
      weight_reg[bus.w_addr] <= bus.w_data;
    end
  end

  generate
    for (genvar gi = 0; gi < N_OUT_P; gi++) begin : g_neuron
      logic [CUR_W_P-1:0] acc_reg, cur_reg, acc_upd;
      logic [CUR_W_P:0]   sum_w;

      assign sum_w = {1'b0, acc_reg} + (CUR_W_P + 1)'(row_sel[gi*W_W_P +: W_W_P]);
`ifdef SYN_SAT_EN
      assign acc_upd = sum_w[CUR_W_P] ? {CUR_W_P{1'b1}} : sum_w[CUR_W_P-1:0];
`else
      assign acc_upd = sum_w[CUR_W_P-1:0];
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
          cur_reg <= '0;
        end else begin
          if (accept) acc_reg <= '0;
          else if (state_reg == SCAN) acc_reg <= acc_upd;
          if (load_out) cur_reg <= (state_reg == SCAN) ? acc_upd : '0;
        end
      end

      assign bus.cur_out[gi*CUR_W_P +: CUR_W_P] = cur_reg;
    end
  endgenerate

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
endmodule

// File: tb/tb_sparse_syn_accum.sv
// Directed, table-driven bench for sparse_syn_accum (8-input default build plus a 32-input instance).
module tb_sparse_syn_accum;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  sparse_syn_accum_if s_if ();
  sparse_syn_accum_if #(.N_IN_P(32)) b_if ();

  sparse_syn_accum u_dut (.clk(clk), .rst_n(rst_n), .bus(s_if));
  sparse_syn_accum #(.N_IN_P(32)) u_big (.clk(clk), .rst_n(rst_n), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  spike;
    logic [31:0] exp_cur;
    int          lat;
  } vec_t;

  vec_t vecs [6];

`ifdef SYN_SAT_EN
  localparam logic [7:0] EXP_ALL = 8'd255;
  localparam logic [7:0] EXP_18  = 8'd255;
`else
  localparam logic [7:0] EXP_ALL = 8'd224;
  localparam logic [7:0] EXP_18  = 8'd14;
`endif

  function automatic logic [15:0] wrow(int a, int b, int c, int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [31:0] cpk(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    s_if.w_we   = 1'b1;
    s_if.w_addr = 3'(addr);
    s_if.w_data = data;
    @(negedge clk);
    s_if.w_we   = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; optionally writes a row during the first SCAN cycle.
  task automatic run_vec(input string name, input logic [7:0] spike, input logic [31:0] exp_cur,
                         input int lat, input bit do_wr, input int waddr, input logic [15:0] wdata);
    int cyc;
    int busy_cnt;
    chk({name, "_ready"}, 64'(s_if.in_ready), 64'd1);
    s_if.in_valid = 1'b1;
    s_if.spike_in = spike;
    @(posedge clk);
    @(negedge clk);
    s_if.in_valid = 1'b0;
    if (do_wr) begin
      s_if.w_we   = 1'b1;
      s_if.w_addr = 3'(waddr);
      s_if.w_data = wdata;
    end
    cyc = 1;
    busy_cnt = 0;
    while (!s_if.out_valid && cyc < 60) begin
      if (s_if.busy) busy_cnt++;
      @(negedge clk);
      s_if.w_we = 1'b0;
      cyc++;
    end
    s_if.w_we = 1'b0;
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_cur"}, 64'(s_if.cur_out), 64'(exp_cur));
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    chk({name, "_busy_at_done"}, 64'(s_if.busy), 64'd0);
    $display("[TB] %s spike=%02h cur=%08h lat=%0d", name, spike, s_if.cur_out, cyc);
    @(negedge clk);
    chk({name, "_pulse_end"}, 64'(s_if.out_valid), 64'd0);
    chk({name, "_idle_again"}, 64'(s_if.in_ready), 64'd1);
  endtask

  task automatic run_big(input string name, input logic [31:0] spike, input logic [7:0] exp0, input int lat);
    int cyc;
    b_if.in_valid = 1'b1;
    b_if.spike_in = spike;
    @(posedge clk);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    cyc = 1;
    while (!b_if.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_n0"}, 64'(b_if.cur_out[7:0]), 64'(exp0));
    chk({name, "_n123"}, 64'(b_if.cur_out[31:8]), 64'd0);
    $display("[TB] %s spike=%08h cur=%08h lat=%0d", name, spike, b_if.cur_out, cyc);
    @(negedge clk);
  endtask

  initial begin
    int ov_seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    s_if.in_valid = 1'b0; s_if.spike_in = '0; s_if.w_we = 1'b0; s_if.w_addr = '0; s_if.w_data = '0;
    b_if.in_valid = 1'b0; b_if.spike_in = '0; b_if.w_we = 1'b0; b_if.w_addr = '0; b_if.w_data = '0;

    vecs[0] = '{8'h00,        cpk(0, 0, 0, 0),     1};
    vecs[1] = '{8'b0100_0010, cpk(6, 10, 0, 30),   3};
    vecs[2] = '{8'h01,        cpk(1, 2, 3, 4),     2};
    vecs[3] = '{8'h83,        cpk(19, 22, 18, 34), 4};
    vecs[4] = '{8'hC0,        cpk(18, 20, 15, 30), 3};
    vecs[5] = '{8'h3C,        cpk(0, 0, 0, 0),     5};

    #3;
    chk("reset_in_ready", 64'(s_if.in_ready), 64'd1);
    chk("reset_out_valid", 64'(s_if.out_valid), 64'd0);
    chk("reset_busy", 64'(s_if.busy), 64'd0);
    chk("reset_cur", 64'(s_if.cur_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, wrow(1, 2, 3, 4));
    wr(1, wrow(3, 5, 0, 15));
    wr(6, wrow(3, 5, 0, 15));
    wr(7, wrow(15, 15, 15, 15));
    for (int i = 0; i < 6; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].spike, vecs[i].exp_cur, vecs[i].lat, 1'b0, 0, '0);

    // Write to the row being scanned: old row used now, new row next timestep.
    wr(2, wrow(1, 1, 1, 1));
    run_vec("coll_old", 8'h04, cpk(1, 1, 1, 1), 2, 1'b1, 2, wrow(2, 2, 2, 2));
    run_vec("coll_new", 8'h04, cpk(2, 2, 2, 2), 2, 1'b0, 0, '0);
    // Row 6 rewritten while row 1 is visited: only correct if row 1 is scanned first.
    run_vec("order", 8'h42, cpk(4, 6, 1, 16), 3, 1'b1, 6, wrow(1, 1, 1, 1));

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cur", 64'(s_if.cur_out), 64'd0);
    chk("async_rst_ready", 64'(s_if.in_ready), 64'd1);
    chk("async_rst_valid", 64'(s_if.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Backpressure during SCAN, then reset mid-scan.
    wr(0, wrow(1, 2, 3, 4));
    wr(1, wrow(3, 5, 0, 15));
    s_if.in_valid = 1'b1;
    s_if.spike_in = 8'h83;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_c1", 64'(s_if.in_ready), 64'd0);
    chk("bp_busy_c1", 64'(s_if.busy), 64'd1);
    @(negedge clk);
    chk("bp_ready_c2", 64'(s_if.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (s_if.out_valid) ov_seen++;
      @(negedge clk);
    end
    chk("midrst_no_out_valid", 64'(ov_seen), 64'd0);
    chk("midrst_ready", 64'(s_if.in_ready), 64'd1);
    chk("midrst_busy", 64'(s_if.busy), 64'd0);
    s_if.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("post_rst_cleared", 8'h83, cpk(0, 0, 0, 0), 4, 1'b0, 0, '0);
    wr(0, wrow(1, 2, 3, 4));
    run_vec("post_rst_normal", 8'h01, cpk(1, 2, 3, 4), 2, 1'b0, 0, '0);

    for (int i = 0; i < 8; i++) wr(i, wrow(15, 0, 0, 0));
    for (int t = 0; t < 3; t++)
      run_vec($sformatf("full_ts%0d", t), 8'hFF, cpk(120, 0, 0, 0), 9, 1'b0, 0, '0);

    for (int i = 0; i < 32; i++) begin
      b_if.w_we   = 1'b1;
      b_if.w_addr = 5'(i);
      b_if.w_data = wrow(15, 0, 0, 0);
      @(negedge clk);
    end
    b_if.w_we = 1'b0;
    @(negedge clk);
    run_big("big17", 32'h0001_FFFF, 8'd255, 18);
    run_big("big18", 32'h0003_FFFF, EXP_18, 19);
    run_big("big_all", 32'hFFFF_FFFF, EXP_ALL, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
